mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data-memory port. Grants are combinational so a granted access
// drives the memory port in the same cycle; read data returns one cycle later
// and is steered to whichever port issued the read.
// Optional feature macro: ARB_STARVE_GUARD_EN -- lets a starved fetch win once
// its consecutive-denial count reaches STARVE_LIMIT.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } own_t;

  own_t       rd_own_reg, rd_own_next;
  logic [2:0] starve_cnt_reg, starve_cnt_next;
  logic       force_if;

  // Arbitration: data wins by default; nothing is granted while in reset.
  always_comb begin
    force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_if = if_req && (starve_cnt_reg >= 3'(STARVE_LIMIT));
`endif
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (force_if) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory port mux: driven from the granted requester, zero when idle.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Next read owner and starvation count; stores never claim the read path.
  always_comb begin
    rd_own_next     = OWN_NONE;
    starve_cnt_next = 3'd0;
    if (if_gnt) begin
      rd_own_next = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      rd_own_next = OWN_DM;
    end
    if (if_req && !if_gnt) begin
      starve_cnt_next = (starve_cnt_reg == 3'd7) ? 3'd7 : starve_cnt_reg + 3'd1;
    end
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_own_reg     <= OWN_NONE;
      starve_cnt_reg <= 3'd0;
    end else begin
      rd_own_reg     <= rd_own_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Read-data return and stall; everything held at zero during reset.
  always_comb begin
    if_rvalid = !rst && (rd_own_reg == OWN_IF);
    dm_rvalid = !rst && (rd_own_reg == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    stall     = !rst && if_req && !if_gnt;
  end

endmodule
